// File: rtl/adder_pipe.sv
// Pipelined unsigned adder with valid/ready flow control, optional saturation,
// per-result carry flag and a delivered-result counter.
module adder_pipe #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] count
);

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] ovf;
    logic [WIDTH-1:0]  data [STAGES];
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic              hole;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  res;

    always_comb begin
        sum = {1'b0, in0} + {1'b0, in1};
        res = ((SATURATE != 0) && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
    end

    // A stage advances iff out_ready or any stage downstream of it is empty;
    // accumulating that top-down avoids a self-referencing adv vector.
    always_comb begin
        adv  = '0;
        load = '0;
        hole = out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            adv[STAGES-1-i]  = hole;
            load[STAGES-1-i] = !vld[STAGES-1-i] || hole;
            hole             = hole || !vld[STAGES-1-i];
        end
        in_ready = load[0];
    end

    // Data only moves with a valid token so idle/X operands never reach out.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld   <= '0;
            ovf   <= '0;
            count <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    data[0] <= res;
                    ovf[0]  <= sum[WIDTH];
                end
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        data[k] <= data[k-1];
                        ovf[k]  <= ovf[k-1];
                    end
                end
            end
            if (vld[STAGES-1] && out_ready) begin
                count <= count + CNT_WIDTH'(1);
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign out       = data[STAGES-1];
    assign overflow  = ovf[STAGES-1];

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed tables/sequences on two
// 8-bit/2-stage instances (wrap and saturate) plus a randomised 3-stage run.
module tb_adder_pipe;

    localparam int unsigned CW   = 5;
    localparam int unsigned CS   = 3;
    localparam int unsigned CSAT = 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn, in_valid, out_ready;
    logic [7:0]  in0, in1;
    logic        a_in_ready, a_out_valid, a_ovf;
    logic [7:0]  a_out;
    logic [15:0] a_count;
    logic        b_in_ready, b_out_valid, b_ovf;
    logic [7:0]  b_out;
    logic [1:0]  b_count;

    logic          c_in_valid, c_out_ready, c_in_ready, c_out_valid, c_ovf;
    logic [CW-1:0] c_in0, c_in1, c_out;
    logic [3:0]    c_count;

    adder_pipe #(.WIDTH(8), .STAGES(2), .SATURATE(0), .CNT_WIDTH(16)) dut_a (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(a_in_ready),
        .in0(in0), .in1(in1), .out_valid(a_out_valid), .out_ready(out_ready),
        .out(a_out), .overflow(a_ovf), .count(a_count));

    adder_pipe #(.WIDTH(8), .STAGES(2), .SATURATE(1), .CNT_WIDTH(2)) dut_b (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(b_in_ready),
        .in0(in0), .in1(in1), .out_valid(b_out_valid), .out_ready(out_ready),
        .out(b_out), .overflow(b_ovf), .count(b_count));

    adder_pipe #(.WIDTH(CW), .STAGES(CS), .SATURATE(CSAT), .CNT_WIDTH(4)) dut_c (
        .clock(clock), .resetn(resetn), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in0(c_in0), .in1(c_in1), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out(c_out), .overflow(c_ovf), .count(c_count));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] wrap;
        logic [7:0] sat;
        logic       ovf;
    } vec_t;

    vec_t vt [6];

    // Reference for instance C: in-flight tokens with their pipeline position.
    int qval [$];
    int qovf [$];
    int qpos [$];
    int mcount;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{a: 8'd200, b: 8'd100, wrap: 8'd44,  sat: 8'd255, ovf: 1'b1};
        vt[1] = '{a: 8'd100, b: 8'd27,  wrap: 8'd127, sat: 8'd127, ovf: 1'b0};
        vt[2] = '{a: 8'd255, b: 8'd1,   wrap: 8'd0,   sat: 8'd255, ovf: 1'b1};
        vt[3] = '{a: 8'd255, b: 8'd255, wrap: 8'd254, sat: 8'd255, ovf: 1'b1};
        vt[4] = '{a: 8'd0,   b: 8'd0,   wrap: 8'd0,   sat: 8'd0,   ovf: 1'b0};
        vt[5] = '{a: 8'd128, b: 8'd127, wrap: 8'd255, sat: 8'd255, ovf: 1'b0};

        resetn = 1'b0; in_valid = 1'b0; in0 = '0; in1 = '0; out_ready = 1'b1;
        c_in_valid = 1'b0; c_out_ready = 1'b0; c_in0 = '0; c_in1 = '0;

        // Reset and idle
        repeat (3) tick();
        check("rst_out_valid", 32'(a_out_valid), 0);
        check("rst_out", 32'(a_out), 0);
        check("rst_ovf", 32'(a_ovf), 0);
        check("rst_count", 32'(a_count), 0);
        resetn = 1'b1;
        tick();
        check("idle_out_valid", 32'(a_out_valid), 0);
        check("idle_in_ready", 32'(a_in_ready), 1);
        check("idle_count", 32'(a_count), 0);

        // Streaming at full rate
        for (int i = 0; i < 12; i++) begin
            if (i < 10) begin
                in_valid = 1'b1; in0 = 8'(i + 1); in1 = 8'(i + 2);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < 10) check("stream_in_ready", 32'(a_in_ready), 1);
            tick();
            if (i >= 1 && i <= 10) begin
                check("stream_valid", 32'(a_out_valid), 1);
                check("stream_out", 32'(a_out), 32'(2 * (i - 1) + 3));
            end else begin
                check("stream_valid", 32'(a_out_valid), 0);
            end
        end
        check("stream_count", 32'(a_count), 10);
        check("stream_count_b", 32'(b_count), 2);

        // Overflow / saturation table
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in0 = vt[i].a; in1 = vt[i].b;
            tick();
            in_valid = 1'b0;
            tick();
            check("ovf_valid", 32'(a_out_valid), 1);
            check("ovf_wrap_out", 32'(a_out), 32'(vt[i].wrap));
            check("ovf_wrap_flag", 32'(a_ovf), 32'(vt[i].ovf));
            check("ovf_sat_out", 32'(b_out), 32'(vt[i].sat));
            check("ovf_sat_flag", 32'(b_ovf), 32'(vt[i].ovf));
        end
        tick();
        check("ovf_count", 32'(a_count), 16);

        // Backpressure: two accepted, third stalls, then drains in order
        out_ready = 1'b0;
        in_valid = 1'b1; in0 = 8'd1; in1 = 8'd1;
        #1 check("bp_ready0", 32'(a_in_ready), 1);
        tick();
        in0 = 8'd2; in1 = 8'd2;
        #1 check("bp_ready1", 32'(a_in_ready), 1);
        tick();
        in0 = 8'd3; in1 = 8'd3;
        #1 check("bp_full", 32'(a_in_ready), 0);
        check("bp_valid", 32'(a_out_valid), 1);
        check("bp_out", 32'(a_out), 2);
        tick();
        check("bp_hold1", 32'(a_out), 2);
        check("bp_full_b", 32'(b_in_ready), 0);
        tick();
        check("bp_hold2", 32'(a_out), 2);
        check("bp_hold_valid", 32'(a_out_valid), 1);
        out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(a_in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("bp_seq1_valid", 32'(a_out_valid), 1);
        check("bp_seq1", 32'(a_out), 4);
        tick();
        check("bp_seq2_valid", 32'(a_out_valid), 1);
        check("bp_seq2", 32'(a_out), 6);
        tick();
        check("bp_empty", 32'(a_out_valid), 0);
        check("bp_count", 32'(a_count), 19);

        // Bubble collapse with unknown idle operands
        out_ready = 1'b0;
        in_valid = 1'b1; in0 = 8'd5; in1 = 8'd5;
        tick();
        in_valid = 1'b0; in0 = 'x; in1 = 'x;
        repeat (3) tick();
        check("bub_valid", 32'(a_out_valid), 1);
        check("bub_out", 32'(a_out), 10);
        in_valid = 1'b1; in0 = 8'd7; in1 = 8'd7;
        #1 check("bub_ready", 32'(a_in_ready), 1);
        tick();
        in_valid = 1'b0; in0 = 'x; in1 = 'x;
        #1 check("bub_full", 32'(a_in_ready), 0);
        check("bub_hold", 32'(a_out), 10);
        out_ready = 1'b1;
        tick();
        check("bub_second_valid", 32'(a_out_valid), 1);
        check("bub_second", 32'(a_out), 14);
        tick();
        check("bub_drained", 32'(a_out_valid), 0);
        check("bub_x_iso", 32'($isunknown(a_out)), 0);
        check("bub_count", 32'(a_count), 21);

        // Mid-operation reset
        out_ready = 1'b0;
        in_valid = 1'b1; in0 = 8'd1; in1 = 8'd2;
        tick();
        in0 = 8'd3; in1 = 8'd4;
        tick();
        in_valid = 1'b0;
        check("mr_inflight", 32'(a_out_valid), 1);
        resetn = 1'b0;
        #1;
        check("mr_valid", 32'(a_out_valid), 0);
        check("mr_out", 32'(a_out), 0);
        check("mr_ovf", 32'(a_ovf), 0);
        check("mr_count", 32'(a_count), 0);
        tick();
        resetn = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr_stale", 32'(a_out_valid), 0);
        end

        // Counter wrap on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in0 = 8'(i); in1 = 8'd1;
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("wrap_count_b", 32'(b_count), 1);
        check("wrap_count_a", 32'(a_count), 5);

        // Randomised run on the 3-stage saturating instance
        mcount = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int unsigned pr;
            bit exp_ready, exp_ov, in_x, out_x;
            pr = ((cyc / 500) % 3 == 0) ? 2 : (((cyc / 500) % 3 == 1) ? 6 : 10);
            c_in_valid  = ($urandom_range(0, 9) < 6);
            c_out_ready = ($urandom_range(0, 9) < pr);
            c_in0 = CW'($urandom);
            c_in1 = CW'($urandom);
            #1;
            exp_ready = (qpos.size() < CS) || c_out_ready;
            exp_ov    = (qpos.size() > 0) && (qpos[0] == CS - 1);
            check("rnd_in_ready", 32'(c_in_ready), 32'(exp_ready));
            check("rnd_out_valid", 32'(c_out_valid), 32'(exp_ov));
            if (exp_ov) begin
                check("rnd_out", 32'(c_out), 32'(qval[0]));
                check("rnd_ovf", 32'(c_ovf), 32'(qovf[0]));
            end
            check("rnd_count", 32'(c_count), 32'(mcount));
            out_x = exp_ov && c_out_ready;
            in_x  = c_in_valid && exp_ready;
            if (out_x) begin
                void'(qval.pop_front());
                void'(qovf.pop_front());
                void'(qpos.pop_front());
                mcount = (mcount + 1) % 16;
            end
            for (int j = 0; j < qpos.size(); j++) begin
                int lim;
                lim = (j == 0) ? int'(CS) - 1 : qpos[j-1] - 1;
                qpos[j] = (qpos[j] + 1 < lim) ? qpos[j] + 1 : lim;
            end
            if (in_x) begin
                int t;
                t = int'(c_in0) + int'(c_in1);
                qovf.push_back((t >= (1 << CW)) ? 1 : 0);
                if (t >= (1 << CW)) qval.push_back((CSAT != 0) ? (1 << CW) - 1 : t - (1 << CW));
                else                qval.push_back(t);
                qpos.push_back(0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined two-operand unsigned adder with valid/ready handshakes on input and output.
- Supports a configurable pipeline depth, optional saturation, an overflow flag and a count of delivered results.
- Sits between a registered producer and a consumer that may apply backpressure.
- Successor to the single-register adder datapath: adds depth, flow control, saturation and bubble collapsing.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- STAGES, 2, pipeline register stages = zero-stall latency in cycles (>=1)
- SATURATE, 0, 0 = result wraps modulo 2^WIDTH; 1 = result clamps to all-ones on carry
- CNT_WIDTH, 16, width of the delivered-result counter

Ports:
- clock  input  1  single clock; all state updates on rising edge
- resetn  input  1  asynchronous, active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands this cycle
- in0  input  WIDTH  operand A
- in1  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result this cycle
- out  output  WIDTH  result
- overflow  output  1  carry-out of the add that produced out (set regardless of SATURATE)
- count  output  CNT_WIDTH  number of results delivered, modulo 2^CNT_WIDTH

Behaviour:
- Interface timing: clock and reset are as stated in Ports; all outputs come from registers except in_ready.
- Reset: while resetn=0 all stage valid bits, data and flags are 0. So out_valid=0, out=0, overflow=0, count=0.
- Reset mid-operation: asserting resetn discards in-flight results; nothing is delivered after deassertion until new input arrives.
- Sum: computed combinationally at the stage-0 input as a WIDTH+1-bit sum {c,s} = in0 + in1.
  - SATURATE=0: result = s.
  - SATURATE=1: result = c ? all-ones : s.
  - overflow = c in both modes.
- Pipeline: stages 0..STAGES-1, each holding {valid, result, overflow}. The last stage drives out_valid, out and overflow.
- Advance rule:
  - adv[STAGES-1] = out_ready.
  - Stage k loads from its upstream source when !valid[k] || adv[k].
  - Stage 0's upstream source is the adder with valid = in_valid.
  - A stage that loads takes the upstream valid bit. An empty upstream therefore writes valid=0, and bubbles collapse.
- Handshake rules:
  - in_ready = !valid[0] || adv[0]. This is a combinational chain from out_ready; there is no combinational path from in_valid to in_ready.
  - An input transfer occurs on in_valid && in_ready. An output transfer occurs on out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out and overflow hold stable.
  - out_valid never drops without a transfer or a reset.
- Latency and throughput:
  - With out_ready held high, a result accepted at edge N appears at out_valid after edge N+STAGES-1. It is visible STAGES cycles after being presented.
  - Throughput is 1 result/cycle; no bubbles are inserted at full rate.
- Capacity: up to STAGES results in flight. When all stages are valid and out_ready=0, in_ready=0.
- Ordering: results are delivered strictly in acceptance order; none are dropped or duplicated.
- Counter: count increments by 1 on each output transfer and wraps from 2^CNT_WIDTH-1 to 0.
- Simultaneous events: an input and an output transfer in the same cycle are both honoured while full, so the pipeline shifts.
- Unknown (X) operands with in_valid=0 must not affect any output.

Test Plan:
- Reset then idle: resetn=0 for 3 cycles, release with in_valid=0 -> out_valid=0, out=0, overflow=0, count=0, in_ready=1.
- Streaming (WIDTH=8, STAGES=2, out_ready=1): in0=1..10, in1=2..11 on consecutive cycles -> out=3,5,...,21, each 2 cycles after presentation; count=10; no gaps.
- Overflow, both modes: 200+100 -> SATURATE=0 gives out=44, overflow=1; SATURATE=1 gives out=255, overflow=1. 100+27 -> out=127, overflow=0.
- Backpressure: out_ready=0 while sending 1+1, 2+2, 3+3 -> in_ready=0 after 2 accepted; out=2 held stable. Raise out_ready -> sequence 2,4,6 delivered in order, none lost.
- Bubble collapse: send 5+5, idle 3 cycles with out_ready=0, send 7+7 -> both stages fill (in_ready=0). Release -> out=10 then 14 on consecutive cycles.
- Mid-operation reset and counter wrap:
  - Assert resetn=0 with 2 results in flight -> outputs go to 0 immediately; after release no stale result appears.
  - With CNT_WIDTH=2, deliver 5 results -> count reads 1.
